// File: rtl/pixel_fetch_pkg.sv
// Shared types and defaults for the pixel_fetch frame streamer.
package pixel_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

    localparam int unsigned FRAME_WORDS_DEF = 38400;
    localparam int unsigned FIFO_DEPTH_DEF  = 64;

    // A memory word carries two pixels; the upper half is shown first.
    function automatic rgb565_t word_pixel(input logic [31:0] word, input logic second);
        rgb565_t px;
        if (second) begin
            px = rgb565_t'(word[15:0]);
        end else begin
            px = rgb565_t'(word[31:16]);
        end
        return px;
    endfunction

endpackage

// File: rtl/pixel_fetch_fifo.sv
// Synchronous show-ahead word FIFO with occupancy count; DEPTH must be a power of two.
module pixel_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign wr_ok_s = wr_en && (count_r != CW'(DEPTH));
    assign rd_ok_s = rd_en && (count_r != {CW{1'b0}});

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;

endmodule

// File: rtl/pixel_fetch.sv
// Fetches one frame of RGB565 word pairs over Avalon-MM and streams pixels on Avalon-ST.
// Build macro PIXEL_FETCH_UNDERFLOW_CNT_EN adds the saturating sink-starvation counter.
module pixel_fetch
    import pixel_fetch_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] frame_base,
    output logic        busy,
    output logic        done,
    output logic        avm_read,
    output logic [23:0] avm_address,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        aso_valid,
    output logic [15:0] aso_data,
    output logic        aso_sop,
    output logic        aso_eop,
    input  logic        aso_ready,
    output logic [31:0] underflow_count
);

    localparam int unsigned WI_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned PX_W = $clog2(2 * FRAME_WORDS);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRW  = CW + 1;

    localparam logic [WI_W-1:0] WORDS_ALL = WI_W'(FRAME_WORDS);
    localparam logic [PX_W-1:0] PIX_LAST  = PX_W'(2 * FRAME_WORDS - 1);
    localparam logic [CRW-1:0]  CREDIT_MAX = CRW'(FIFO_DEPTH);

    state_e          state_r;
    state_e          state_s;
    logic            read_r;
    logic            read_s;
    logic [23:0]     addr_r;
    logic [23:0]     addr_s;
    logic [WI_W-1:0] words_r;
    logic [WI_W-1:0] words_next_s;
    logic [CW-1:0]   pending_r;
    logic [CW-1:0]   pending_next_s;
    logic [PX_W-1:0] pix_r;
    logic            half_r;
    logic            busy_r;
    logic            done_r;

    logic            start_ok_s;
    logic            accept_s;
    logic            rdv_s;
    logic            pix_acc_s;
    logic            pop_s;
    logic            last_pix_s;
    logic [CRW-1:0]  credit_s;
    logic [31:0]     fifo_word_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;

    assign start_ok_s     = start && (state_r == ST_IDLE);
    assign accept_s       = read_r && !avm_waitrequest;
    assign rdv_s          = avm_readdatavalid && (state_r != ST_IDLE);
    assign pix_acc_s      = aso_valid && aso_ready;
    assign pop_s          = pix_acc_s && half_r;
    assign last_pix_s     = pix_acc_s && (pix_r == PIX_LAST);
    assign words_next_s   = words_r + WI_W'(accept_s);
    assign pending_next_s = pending_r + CW'(accept_s) - CW'(rdv_s);
    // Words in flight plus words buffered after this cycle's accept and pop.
    assign credit_s       = {1'b0, pending_r} + {1'b0, fifo_count_s}
                          + CRW'(accept_s) - CRW'(pop_s);

    pixel_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_ok_s),
        .wr_en   (rdv_s),
        .wr_data (avm_readdata),
        .rd_en   (pop_s),
        .rd_data (fifo_word_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Next-state and next request decode.
    always_comb begin
        state_s = state_r;
        read_s  = 1'b0;
        addr_s  = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_FETCH;
                    read_s  = 1'b1;
                    addr_s  = frame_base;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (read_r && avm_waitrequest) begin
                    read_s = 1'b1;
                end else begin
                    read_s = (words_next_s < WORDS_ALL) && (credit_s < CREDIT_MAX);
                end
                if (accept_s) begin
                    addr_s = addr_r + 24'd4;
                end else begin
                    addr_s = addr_r;
                end
                if (accept_s && (words_next_s == WORDS_ALL)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (last_pix_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and Avalon-MM request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            read_r  <= 1'b0;
            addr_r  <= 24'd0;
        end else begin
            state_r <= state_s;
            read_r  <= read_s;
            addr_r  <= addr_s;
        end
    end

    // Frame progress counters: words requested, words in flight, pixels delivered.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            words_r   <= {WI_W{1'b0}};
            pending_r <= {CW{1'b0}};
            pix_r     <= {PX_W{1'b0}};
            half_r    <= 1'b0;
        end else begin
            words_r   <= words_next_s;
            pending_r <= pending_next_s;
            if (pix_acc_s) begin
                pix_r  <= pix_r + PX_W'(1'b1);
                half_r <= ~half_r;
            end
        end
    end

    // Frame status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start_ok_s) begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_DRAIN) && last_pix_s;
            busy_r <= busy_r && !((state_r == ST_DRAIN) && last_pix_s);
        end
    end

`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
    logic [31:0] underflow_r;

    // Counts cycles the sink waited on an empty pipeline during a frame.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            underflow_r <= 32'd0;
        end else if (busy_r && aso_ready && !aso_valid && (underflow_r != 32'hFFFF_FFFF)) begin
            underflow_r <= underflow_r + 32'd1;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign underflow_count = underflow_r;
`else
    assign underflow_count = 32'd0;
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign avm_read    = read_r;
    assign avm_address = addr_r;
    assign aso_valid   = !fifo_empty_s;
    assign aso_data    = word_pixel(fifo_word_s, half_r);
    assign aso_sop     = aso_valid && (pix_r == {PX_W{1'b0}});
    assign aso_eop     = aso_valid && (pix_r == PIX_LAST);

endmodule
